// File: rtl/cs_seq.sv
// cs_seq: multi-cycle single-bit rotator with valid/ready handshakes on both sides.
// Define CS_SEQ_DIR_EN to add in_dir (1 = rotate left, 0 = rotate right).
module cs_seq #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AW-1:0]    in_amt,
`ifdef CS_SEQ_DIR_EN
    input  logic             in_dir,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic [AW-1:0]    steps_left
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] word_rot;
    logic             in_xfer;
    logic             last_step;

`ifdef CS_SEQ_DIR_EN
    logic dir;

    always_comb begin
        if (dir) word_rot = {word[WIDTH-2:0], word[WIDTH-1]};
        else     word_rot = {word[0], word[WIDTH-1:1]};
    end
`else
    always_comb begin
        word_rot = {word[0], word[WIDTH-1:1]};
    end
`endif

    assign in_xfer   = in_valid & in_ready;
    assign last_step = (steps_left == AW'(1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_amt == '0) state_nx = DONE;
                    else              state_nx = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_step) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // out_data only changes when a result completes, so it holds through IDLE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            word       <= '0;
            steps_left <= '0;
            out_data   <= '0;
`ifdef CS_SEQ_DIR_EN
            dir        <= 1'b0;
`endif
        end else if (in_xfer) begin
            word       <= in_data;
            steps_left <= in_amt;
`ifdef CS_SEQ_DIR_EN
            dir        <= in_dir;
`endif
            if (in_amt == '0) out_data <= in_data;
        end else if (busy) begin
            word       <= word_rot;
            steps_left <= steps_left - AW'(1);
            if (last_step) out_data <= word_rot;
        end
    end

endmodule

// File: tb/tb_cs_seq.sv
// Self-checking bench for cs_seq: vector table of rotations plus
// backpressure, asynchronous reset and direction sequences.
module tb_cs_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_amt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;
    logic [4:0]  steps_left;
`ifdef CS_SEQ_DIR_EN
    logic        in_dir;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clock = ~clock;

    cs_seq #(.WIDTH(32), .AW(5)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_amt     (in_amt),
`ifdef CS_SEQ_DIR_EN
        .in_dir     (in_dir),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .steps_left (steps_left)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  amt;
        logic [31:0] expv;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Presents one word, measures latency and busy cycles, then drains it.
    task automatic run_op(input logic [31:0] d, input logic [4:0] a,
                          input logic dir, input logic [31:0] expv,
                          input string name);
        int n;
        int bcnt;
        @(negedge clock);
        chk({name, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_data   = d;
        in_amt    = a;
        out_ready = 1'b1;
`ifdef CS_SEQ_DIR_EN
        in_dir    = dir;
`else
        if (dir) $display("note: dir ignored in this build");
`endif
        tick();
        in_valid = 1'b0;
        in_data  = 32'hFFFF_FFFF;
        n    = 1;
        bcnt = 0;
        while (!out_valid && n < 100) begin
            if (busy) bcnt++;
            tick();
            n++;
        end
        chk({name, " out_valid"}, 32'(out_valid), 32'd1);
        chk({name, " latency"}, 32'(n), 32'(a) + 32'd1);
        chk({name, " busy cycles"}, 32'(bcnt), 32'(a));
        chk({name, " out_data"}, out_data, expv);
        tick();
        chk({name, " drained"}, 32'(out_valid), 32'd0);
        chk({name, " idle in_ready"}, 32'(in_ready), 32'd1);
        chk({name, " held result"}, out_data, expv);
        out_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{32'h0000_0001, 5'd1,  32'h8000_0000};
        vecs[1] = '{32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
        vecs[2] = '{32'h1234_5678, 5'd31, 32'h2468_ACF0};
        vecs[3] = '{32'h0000_000F, 5'd4,  32'hF000_0000};
        vecs[4] = '{32'h1234_5678, 5'd4,  32'h8123_4567};
        vecs[5] = '{32'h1234_5678, 5'd16, 32'h5678_1234};
        vecs[6] = '{32'hA5A5_A5A5, 5'd1,  32'hD2D2_D2D2};
        vecs[7] = '{32'h8000_0000, 5'd8,  32'h0080_0000};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        out_ready = 1'b0;
`ifdef CS_SEQ_DIR_EN
        in_dir    = 1'b0;
`endif
        tick();
        tick();
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst steps_left", 32'(steps_left), 32'd0);
        chk("rst out_data", out_data, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 8; i++)
            run_op(vecs[i].data, vecs[i].amt, 1'b0, vecs[i].expv,
                   $sformatf("vec%0d", i));

        // Backpressure: result held while a new word waits at the input.
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = 32'h0000_00F0;
        in_amt   = 5'd4;
        tick();
        in_data  = 32'h1111_1111;
        in_amt   = 5'd0;
        for (int n = 0; n < 20 && !out_valid; n++) tick();
        chk("bp out_valid", 32'(out_valid), 32'd1);
        for (int k = 0; k < 10; k++) begin
            chk("bp stable data", out_data, 32'h0000_000F);
            chk("bp in_ready low", 32'(in_ready), 32'd0);
            chk("bp valid held", 32'(out_valid), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp idle valid", 32'(out_valid), 32'd0);
        chk("bp idle ready", 32'(in_ready), 32'd1);
        chk("bp not captured", out_data, 32'h0000_000F);
        tick();
        in_valid = 1'b0;
        chk("bp new accepted", 32'(out_valid), 32'd1);
        chk("bp new data", out_data, 32'h1111_1111);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp drained", 32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of a shift.
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = 32'h1234_5678;
        in_amt   = 5'd20;
        tick();
        in_valid = 1'b0;
        for (int n = 0; n < 40 && steps_left != 5'd7; n++) tick();
        chk("ar steps 7", 32'(steps_left), 32'd7);
        chk("ar busy pre", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar out_valid", 32'(out_valid), 32'd0);
        chk("ar busy", 32'(busy), 32'd0);
        chk("ar in_ready", 32'(in_ready), 32'd1);
        chk("ar steps", 32'(steps_left), 32'd0);
        chk("ar out_data", out_data, 32'd0);
        #1;
        reset = 1'b0;
        tick();
        tick();
        chk("ar no partial", 32'(out_valid), 32'd0);
        run_op(32'h0000_000F, 5'd4, 1'b0, 32'hF000_0000, "ar after");

`ifdef CS_SEQ_DIR_EN
        run_op(32'h8000_0000, 5'd1, 1'b1, 32'h0000_0001, "dir left1");
        run_op(32'h1234_5678, 5'd4, 1'b1, 32'h2345_6781, "dir left4");
        run_op(32'h1234_5678, 5'd4, 1'b0, 32'h8123_4567, "dir right4");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/cs_seq.md
CS_SEQ -- requirements
Module: cs_seq

Interface
REQ-001 Parameter: WIDTH, default 32, data word width in bits.
REQ-002 Parameter: AW, default 5, rotate-amount width; 2**AW SHALL equal WIDTH.
REQ-003 Port: clock, input, 1, rising-edge clock for all state.
REQ-004 Port: reset, input, 1, asynchronous active-high reset.
REQ-005 Port: in_valid, input, 1, producer offers a word and an amount.
REQ-006 Port: in_ready, output, 1, block accepts a new word.
REQ-007 Port: in_data, input, WIDTH, word to rotate.
REQ-008 Port: in_amt, input, AW, number of single-bit right-rotate steps.
REQ-009 Port: out_valid, output, 1, out_data holds a finished result.
REQ-010 Port: out_ready, input, 1, consumer takes the result.
REQ-011 Port: out_data, output, WIDTH, rotated word, registered.
REQ-012 Port: busy, output, 1, high while in SHIFT.
REQ-013 Port: steps_left, output, AW, remaining steps, registered.

Function
REQ-014 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-015 The block SHALL drive in_ready high only in IDLE; an input transfer SHALL occur when in_valid and in_ready are both high on a clock edge.
REQ-016 On an input transfer, the block SHALL load in_data into the word register and in_amt into steps_left; it SHALL go to SHIFT if in_amt != 0, else to DONE.
REQ-017 In SHIFT, each cycle SHALL apply one right rotate, word <= {word[0], word[WIDTH-1:1]}, so bit i takes old bit i+1 and bit WIDTH-1 takes old bit 0; steps_left SHALL decrement by 1.
REQ-018 The block SHALL move from SHIFT to DONE on the cycle steps_left goes from 1 to 0; latency from accept to out_valid SHALL be in_amt+1 cycles, minimum 1.
REQ-019 In DONE, out_valid SHALL be high and out_data SHALL equal the word register; both SHALL stay stable until an output transfer.
REQ-020 An output transfer SHALL occur when out_valid and out_ready are both high on a clock edge; the block SHALL then return to IDLE.
REQ-021 While in IDLE, out_data SHALL hold the last result; in_data SHALL be ignored unless a transfer occurs.
REQ-022 out_ready asserted outside DONE SHALL have no effect; in_valid outside IDLE SHALL have no effect and SHALL NOT be captured.
REQ-023 An input and an output transfer SHALL never occur on the same edge (no bypass); a new word SHALL be accepted no earlier than one cycle after an output transfer.
REQ-024 busy SHALL equal (state == SHIFT).

Reset
REQ-025 When reset is asserted, the block SHALL immediately, without a clock edge, set state=IDLE, out_data=0, steps_left=0, out_valid=0, busy=0 and in_ready=1.
REQ-026 Reset asserted during SHIFT or DONE SHALL discard the operation in progress; no partial result SHALL appear after release.
REQ-027 The first input transfer SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-028 Macro CS_SEQ_DIR_EN: when defined, the block SHALL add an input port in_dir, width 1, that is captured on the input transfer; the value 1 SHALL select left rotate, word <= {word[WIDTH-2:0], word[WIDTH-1]}, and the value 0 SHALL select right rotate.
REQ-029 When CS_SEQ_DIR_EN is not defined, the in_dir port SHALL be absent and every rotate SHALL be a right rotate.

Verification
REQ-030 Accept test: in_data=0x00000001, in_amt=1, out_ready=1 -> out_valid rises 2 cycles after accept and out_data=0x80000000.
REQ-031 Zero-amount test: in_data=0xDEADBEEF, in_amt=0 -> no SHIFT state, out_valid rises 1 cycle after accept and out_data=0xDEADBEEF.
REQ-032 Maximum-amount test: in_data=0x12345678, in_amt=31 -> busy is high for 31 cycles and out_data=0x2468ACF0, which equals rotate-left by 1.
REQ-033 Backpressure test: hold out_ready=0 for 10 cycles in DONE while in_valid=1 with new data -> out_data is stable, in_ready=0, nothing is captured; after out_ready=1 the block returns to IDLE and then accepts the new word.
REQ-034 Reset test: assert reset asynchronously mid-SHIFT with steps_left=7 -> all outputs take their reset values before the next clock edge; after release, in_amt=4 on 0x0000000F gives 0xF0000000.
REQ-035 With CS_SEQ_DIR_EN defined, in_dir=1, in_data=0x80000000 and in_amt=1 -> out_data=0x00000001.
